hazard_unit_md: RTL and testbench
=================================

# hazard_unit_md

Parametrised successor of the five-stage pipeline hazard unit. It covers:
- E- and D-stage forwarding.
- Load-use and branch stalls.
- Scoreboarding of a multi-cycle multiply/divide unit (HI/LO) with a busy counter.
- Whole-pipeline freeze on a variable-latency data-memory handshake.
- A saturating stall-cycle counter for performance monitoring.

It sits beside the datapath and drives the enable/flush controls of every pipeline register.

## Interface
Parameters:
- REGBITS, 5, register-specifier width (2**REGBITS architectural registers).
- MDLAT, 4, multiply/divide latency in cycles, ≥1.
- CNTW, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rsD, rtD, rsE, rtE  in  REGBITS each  source specifiers in D and E.
- writeregE, writeregM, writeregW  in  REGBITS each  destination specifiers.
- regwriteE, regwriteM, regwriteW  in  1 each  destination write enables.
- memtoregE, memtoregM  in  1 each  load in stage.
- branchD  in  1  branch in D.
- mdstartD, mdstartE  in  1 each  mult/div instruction in D / E.
- hiloreadD  in  1  mfhi/mflo in D.
- memaccessM  in  1  load/store in M.
- memreadyM  in  1  data memory completes this cycle.
- clrcount  in  1  synchronous clear of stall counter.
- forwardaD, forwardbD  out  1 each  D-stage comparator source is ALUOutM.
- forwardaE, forwardbE  out  2 each  00 register file, 01 ResultW, 10 ALUOutM.
- stallF, stallD, stallE, stallM  out  1 each  hold pipeline register.
- flushE, flushW  out  1 each  insert bubble.
- mdbusy  out  1  mult/div unit occupied.
- stallcount  out  CNTW  saturating count of cycles with stallF high.

## Operation
Forwarding (combinational):
- A specifier equal to 0 never forwards.
- forwardaE = 10 if rsE==writeregM & regwriteM; else 01 if rsE==writeregW & regwriteW; else 00. Same rule for forwardbE with rtE. M has priority over W.
- forwardaD = rsD≠0 & rsD==writeregM & regwriteM. Same rule for forwardbD with rtD.

Stall terms (zero specifier never matches):
- lwstall = memtoregE & writeregE≠0 & (writeregE==rsD | writeregE==rtD).
- brstall = branchD & ((regwriteE & writeregE matches rsD/rtD) | (memtoregM & writeregM matches rsD/rtD)).
- mdstall = (hiloreadD | mdstartD) & (mdbusy | mdstartE).
- memstall = memaccessM & ~memreadyM.

Output priority:
- memstall=1: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0. E is held, not flushed; D-stage stalls are masked.
- Else any of lwstall/brstall/mdstall: stallF=stallD=1, flushE=1, stallE=stallM=flushW=0.
- Else all stall/flush outputs are 0.

Mult/div counter mdcnt (width clog2(MDLAT+1)):
- At a rising edge with mdstartE & ~stallE: load MDLAT.
- Else if mdcnt≠0: decrement. The counter keeps decrementing during memstall; the unit is independent of the pipeline.
- mdbusy = (mdcnt≠0).

Stall counter:
- At each edge: if clrcount, clear to 0 (clrcount has priority).
- Else if stallF and not all-ones, increment. Holds at 2**CNTW−1.

## Timing
- Reset (asynchronous): mdcnt=0, stallcount=0, mdbusy=0. With inputs at 0, all outputs are 0.
- All forwarding and stall/flush outputs are combinational, same-cycle.
- mdbusy rises the cycle after the mdstartE issue edge and stays high exactly MDLAT cycles.
- The first cycle an mfhi in D proceeds is the cycle mdbusy is low again.
- An mfhi entering D in the same cycle the mult is in E stalls for MDLAT+1 cycles total.
- Reset mid-operation clears mdcnt immediately; mdbusy drops without waiting for a clock.
- stallcount reflects a stall cycle one edge later.

## Test plan
- Forwarding priority: rsE=rtE=5, writeregM=writeregW=5, regwriteM=regwriteW=1 -> forwardaE=forwardbE=10. With regwriteM=0 -> 01. With rsE=rtE=0 -> 00.
- Load-use: memtoregE=1, writeregE=8, rsD=8 -> stallF=stallD=flushE=1 for one cycle. With writeregE=0 -> no stall.
- Mult/div, MDLAT=4: mdstartE issue, then hiloreadD=1 held -> stallD high 5 cycles, mdbusy high 4 cycles, stallcount=5 afterward.
- Memory handshake: memaccessM=1, memreadyM=0 for 3 cycles while lwstall also true -> stallF/D/E/M=1, flushW=1, flushE=0 each cycle. Afterwards lwstall drives flushE.
- Reset/saturation: assert reset with mdcnt=2 -> mdbusy=0 asynchronously. With CNTW=2, 5 stall cycles -> stallcount=3. clrcount -> 0.

Source files
------------

// File: rtl/hazard_unit_md_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_md_if
// Description : Datapath <-> hazard unit signal bundle (specifiers, enables,
//               forwarding selects, stall/flush controls, stall counter).
// Revision    : 1.0
// ============================================================================
interface hazard_unit_md_if #(
    parameter int REGBITS = 5,
    parameter int CNTW    = 16
);
    logic [REGBITS-1:0] rsD, rtD, rsE, rtE;
    logic [REGBITS-1:0] writeregE, writeregM, writeregW;
    logic               regwriteE, regwriteM, regwriteW;
    logic               memtoregE, memtoregM;
    logic               branchD;
    logic               mdstartD, mdstartE;
    logic               hiloreadD;
    logic               memaccessM, memreadyM;
    logic               clrcount;

    logic               forwardaD, forwardbD;
    logic [1:0]         forwardaE, forwardbE;
    logic               stallF, stallD, stallE, stallM;
    logic               flushE, flushW;
    logic               mdbusy;
    logic [CNTW-1:0]    stallcount;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, mdstartD, mdstartE, hiloreadD,
               memaccessM, memreadyM, clrcount,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
               stallF, stallD, stallE, stallM, flushE, flushW,
               mdbusy, stallcount
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, mdstartD, mdstartE, hiloreadD,
               memaccessM, memreadyM, clrcount,
        output forwardaD, forwardbD, forwardaE, forwardbE,
               stallF, stallD, stallE, stallM, flushE, flushW,
               mdbusy, stallcount
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit_md.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_md
// Description : Five-stage pipeline hazard unit with forwarding, load-use and
//               branch stalls, mult/div scoreboard, memory-wait freeze and a
//               saturating stall-cycle counter.
// Revision    : 1.0
// ============================================================================
module hazard_unit_md #(
    parameter int REGBITS = 5,
    parameter int MDLAT   = 4,
    parameter int CNTW    = 16
) (
    input  wire              clk,
    input  wire              reset,
    hazard_unit_md_if.slave  hz
);

    localparam int                 c_MDCNTW = $clog2(MDLAT + 1);
    localparam logic [REGBITS-1:0] c_ZERO   = {REGBITS{1'b0}};
    localparam logic [c_MDCNTW-1:0] c_MDLOAD = c_MDCNTW'(MDLAT);

    logic [c_MDCNTW-1:0] r_mdCnt;
    logic [CNTW-1:0]     r_stallCount;

    logic       w_mdBusy;
    logic       w_lwStall, w_brStall, w_mdStall, w_memStall, w_dStall;
    logic       w_brMatchE, w_brMatchM;
    logic [1:0] w_forwardaE, w_forwardbE;
    logic       w_forwardaD, w_forwardbD;
    logic       w_stallF, w_stallD, w_stallE, w_stallM, w_flushE, w_flushW;

    assign w_mdBusy = (r_mdCnt != '0);

    always_comb begin
        w_forwardaE = 2'b00;
        if (hz.rsE != c_ZERO && hz.rsE == hz.writeregM && hz.regwriteM)
            w_forwardaE = 2'b10;
        else if (hz.rsE != c_ZERO && hz.rsE == hz.writeregW && hz.regwriteW)
            w_forwardaE = 2'b01;

        w_forwardbE = 2'b00;
        if (hz.rtE != c_ZERO && hz.rtE == hz.writeregM && hz.regwriteM)
            w_forwardbE = 2'b10;
        else if (hz.rtE != c_ZERO && hz.rtE == hz.writeregW && hz.regwriteW)
            w_forwardbE = 2'b01;
    end

    assign w_forwardaD = (hz.rsD != c_ZERO) && (hz.rsD == hz.writeregM) && hz.regwriteM;
    assign w_forwardbD = (hz.rtD != c_ZERO) && (hz.rtD == hz.writeregM) && hz.regwriteM;

    // A zero destination can never match a source, so checking it once suffices.
    assign w_lwStall  = hz.memtoregE && (hz.writeregE != c_ZERO) &&
                        ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    assign w_brMatchE = hz.regwriteE && (hz.writeregE != c_ZERO) &&
                        ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    assign w_brMatchM = hz.memtoregM && (hz.writeregM != c_ZERO) &&
                        ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));
    assign w_brStall  = hz.branchD && (w_brMatchE || w_brMatchM);
    assign w_mdStall  = (hz.hiloreadD || hz.mdstartD) && (w_mdBusy || hz.mdstartE);
    assign w_memStall = hz.memaccessM && !hz.memreadyM;
    assign w_dStall   = w_lwStall || w_brStall || w_mdStall;

    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushE = 1'b0;
        w_flushW = 1'b0;
        // A memory wait freezes everything; E must be held, not bubbled.
        if (w_memStall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_flushW = 1'b1;
        end else if (w_dStall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_flushE = 1'b1;
        end
    end

    // The mult/div unit runs independently of pipeline freezes once issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdCnt <= '0;
        end else if (hz.mdstartE && !w_stallE) begin
            r_mdCnt <= c_MDLOAD;
        end else if (r_mdCnt != '0) begin
            r_mdCnt <= r_mdCnt - c_MDCNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCount <= '0;
        end else if (hz.clrcount) begin
            r_stallCount <= '0;
        end else if (w_stallF && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + CNTW'(1);
        end
    end

    assign hz.forwardaD  = w_forwardaD;
    assign hz.forwardbD  = w_forwardbD;
    assign hz.forwardaE  = w_forwardaE;
    assign hz.forwardbE  = w_forwardbE;
    assign hz.stallF     = w_stallF;
    assign hz.stallD     = w_stallD;
    assign hz.stallE     = w_stallE;
    assign hz.stallM     = w_stallM;
    assign hz.flushE     = w_flushE;
    assign hz.flushW     = w_flushW;
    assign hz.mdbusy     = w_mdBusy;
    assign hz.stallcount = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_md
// Description : Directed self-checking bench for hazard_unit_md.
// Revision    : 1.0
// ============================================================================
module tb_hazard_unit_md;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    hazard_unit_md_if #(.REGBITS(5), .CNTW(16)) hz ();
    hazard_unit_md_if #(.REGBITS(5), .CNTW(2))  hz2 ();

    hazard_unit_md #(.REGBITS(5), .MDLAT(4), .CNTW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    hazard_unit_md #(.REGBITS(5), .MDLAT(4), .CNTW(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
        hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
        hz.regwriteE = 0; hz.regwriteM = 0; hz.regwriteW = 0;
        hz.memtoregE = 0; hz.memtoregM = 0; hz.branchD = 0;
        hz.mdstartD = 0; hz.mdstartE = 0; hz.hiloreadD = 0;
        hz.memaccessM = 0; hz.memreadyM = 0; hz.clrcount = 0;
        hz2.rsD = '0; hz2.rtD = '0; hz2.rsE = '0; hz2.rtE = '0;
        hz2.writeregE = '0; hz2.writeregM = '0; hz2.writeregW = '0;
        hz2.regwriteE = 0; hz2.regwriteM = 0; hz2.regwriteW = 0;
        hz2.memtoregE = 0; hz2.memtoregM = 0; hz2.branchD = 0;
        hz2.mdstartD = 0; hz2.mdstartE = 0; hz2.hiloreadD = 0;
        hz2.memaccessM = 0; hz2.memreadyM = 0; hz2.clrcount = 0;
    endtask

    task automatic clear_count();
        hz.clrcount = 1;
        step();
        hz.clrcount = 0;
    endtask

    task automatic test_reset();
        logic [5:0] ctrl;
        reset = 1;
        clear_inputs();
        #3;
        ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        nvec++;
        if (ctrl !== 6'b0) begin
            nfail++; $display("FAIL reset_ctrl actual=%b required=%b", ctrl, 6'b0);
        end
        nvec++;
        if ({hz.forwardaE, hz.forwardbE, hz.forwardaD, hz.forwardbD} !== 6'b0) begin
            nfail++; $display("FAIL reset_fwd actual=%b required=%b",
                              {hz.forwardaE, hz.forwardbE, hz.forwardaD, hz.forwardbD}, 6'b0);
        end
        nvec++;
        if (hz.mdbusy !== 1'b0 || hz.stallcount !== 16'd0) begin
            nfail++; $display("FAIL reset_state actual=%b/%0d required=0/0", hz.mdbusy, hz.stallcount);
        end
        step();
        reset = 0;
        step();
    endtask

    task automatic test_forwarding();
        hz.rsE = 5; hz.rtE = 5; hz.writeregM = 5; hz.writeregW = 5;
        hz.regwriteM = 1; hz.regwriteW = 1;
        #1;
        nvec++;
        if ({hz.forwardaE, hz.forwardbE} !== 4'b1010) begin
            nfail++; $display("FAIL fwd_m_priority actual=%b required=%b", {hz.forwardaE, hz.forwardbE}, 4'b1010);
        end
        hz.regwriteM = 0;
        #1;
        nvec++;
        if ({hz.forwardaE, hz.forwardbE} !== 4'b0101) begin
            nfail++; $display("FAIL fwd_w actual=%b required=%b", {hz.forwardaE, hz.forwardbE}, 4'b0101);
        end
        hz.rsE = 0; hz.rtE = 0; hz.writeregM = 0; hz.writeregW = 0; hz.regwriteM = 1;
        #1;
        nvec++;
        if ({hz.forwardaE, hz.forwardbE} !== 4'b0000) begin
            nfail++; $display("FAIL fwd_zero actual=%b required=%b", {hz.forwardaE, hz.forwardbE}, 4'b0000);
        end
        hz.rsE = 3; hz.rtE = 7; hz.writeregW = 3; hz.writeregM = 7;
        #1;
        nvec++;
        if ({hz.forwardaE, hz.forwardbE} !== 4'b0110) begin
            nfail++; $display("FAIL fwd_split actual=%b required=%b", {hz.forwardaE, hz.forwardbE}, 4'b0110);
        end
        hz.rsD = 7; hz.rtD = 9;
        #1;
        nvec++;
        if ({hz.forwardaD, hz.forwardbD} !== 2'b10) begin
            nfail++; $display("FAIL fwd_d actual=%b required=%b", {hz.forwardaD, hz.forwardbD}, 2'b10);
        end
        hz.rsD = 0; hz.rtD = 0; hz.writeregM = 0;
        #1;
        nvec++;
        if ({hz.forwardaD, hz.forwardbD} !== 2'b00) begin
            nfail++; $display("FAIL fwd_d_zero actual=%b required=%b", {hz.forwardaD, hz.forwardbD}, 2'b00);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        logic [5:0] ctrl;
        clear_count();
        hz.memtoregE = 1; hz.writeregE = 8; hz.rsD = 8;
        #1;
        ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        nvec++;
        if (ctrl !== 6'b110010) begin
            nfail++; $display("FAIL lwstall actual=%b required=%b", ctrl, 6'b110010);
        end
        step();
        hz.memtoregE = 0;
        #1;
        ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        nvec++;
        if (ctrl !== 6'b0 || hz.stallcount !== 16'd1) begin
            nfail++; $display("FAIL lwstall_release actual=%b/%0d required=%b/1", ctrl, hz.stallcount, 6'b0);
        end
        hz.memtoregE = 1; hz.writeregE = 0; hz.rsD = 0;
        #1;
        nvec++;
        if (hz.stallF !== 1'b0) begin
            nfail++; $display("FAIL lwstall_zero actual=%b required=0", hz.stallF);
        end
        clear_inputs();
        hz.branchD = 1; hz.regwriteE = 1; hz.writeregE = 4; hz.rtD = 4;
        #1;
        nvec++;
        if ({hz.stallD, hz.flushE} !== 2'b11) begin
            nfail++; $display("FAIL brstall_e actual=%b required=11", {hz.stallD, hz.flushE});
        end
        hz.regwriteE = 0; hz.memtoregM = 1; hz.writeregM = 4;
        #1;
        nvec++;
        if ({hz.stallD, hz.flushE} !== 2'b11) begin
            nfail++; $display("FAIL brstall_m actual=%b required=11", {hz.stallD, hz.flushE});
        end
        hz.branchD = 0;
        #1;
        nvec++;
        if ({hz.stallD, hz.flushE} !== 2'b00) begin
            nfail++; $display("FAIL brstall_nobranch actual=%b required=00", {hz.stallD, hz.flushE});
        end
        clear_inputs();
        step();
    endtask

    task automatic test_muldiv();
        logic [5:0] ctrl;
        clear_count();
        hz.mdstartE = 1; hz.hiloreadD = 1;
        #1;
        ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        nvec++;
        if (ctrl !== 6'b110010 || hz.mdbusy !== 1'b0) begin
            nfail++; $display("FAIL md_issue actual=%b/%b required=%b/0", ctrl, hz.mdbusy, 6'b110010);
        end
        step();
        hz.mdstartE = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nvec++;
            if (hz.mdbusy !== 1'b1 || hz.stallD !== 1'b1) begin
                nfail++; $display("FAIL md_busy_c%0d actual=%b/%b required=1/1", i, hz.mdbusy, hz.stallD);
            end
            step();
        end
        nvec++;
        if (hz.mdbusy !== 1'b0 || hz.stallD !== 1'b0) begin
            nfail++; $display("FAIL md_done actual=%b/%b required=0/0", hz.mdbusy, hz.stallD);
        end
        nvec++;
        if (hz.stallcount !== 16'd5) begin
            nfail++; $display("FAIL md_stallcount actual=%0d required=5", hz.stallcount);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_memstall();
        logic [5:0] ctrl;
        hz.memaccessM = 1; hz.memreadyM = 0;
        hz.memtoregE = 1; hz.writeregE = 8; hz.rsD = 8;
        hz.mdstartE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
            nvec++;
            if (ctrl !== 6'b111101) begin
                nfail++; $display("FAIL memstall_c%0d actual=%b required=%b", i, ctrl, 6'b111101);
            end
            step();
            if (i == 0) begin
                hz.mdstartE = 0;
                #1;
                nvec++;
                if (hz.mdbusy !== 1'b0) begin
                    nfail++; $display("FAIL memstall_md_hold actual=%b required=0", hz.mdbusy);
                end
            end
        end
        hz.memreadyM = 1;
        #1;
        ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushW};
        nvec++;
        if (ctrl !== 6'b110010) begin
            nfail++; $display("FAIL memstall_release actual=%b required=%b", ctrl, 6'b110010);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        hz.mdstartE = 1;
        step();
        hz.mdstartE = 0;
        step();
        step();
        nvec++;
        if (hz.mdbusy !== 1'b1) begin
            nfail++; $display("FAIL areset_pre actual=%b required=1", hz.mdbusy);
        end
        #2;
        reset = 1;
        #1;
        nvec++;
        if (hz.mdbusy !== 1'b0 || hz.stallcount !== 16'd0) begin
            nfail++; $display("FAIL areset_async actual=%b/%0d required=0/0", hz.mdbusy, hz.stallcount);
        end
        #1;
        reset = 0;
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] expCnt;
        hz2.clrcount = 1;
        step();
        hz2.clrcount = 0;
        hz2.memtoregE = 1; hz2.writeregE = 8; hz2.rsD = 8;
        for (int i = 1; i <= 5; i++) begin
            step();
            expCnt = (i > 3) ? 2'd3 : 2'(i);
            nvec++;
            if (hz2.stallcount !== expCnt) begin
                nfail++; $display("FAIL sat_c%0d actual=%0d required=%0d", i, hz2.stallcount, expCnt);
            end
        end
        hz2.clrcount = 1;
        step();
        nvec++;
        if (hz2.stallcount !== 2'd0) begin
            nfail++; $display("FAIL sat_clr_priority actual=%0d required=0", hz2.stallcount);
        end
        hz2.clrcount = 0;
        step();
        nvec++;
        if (hz2.stallcount !== 2'd1) begin
            nfail++; $display("FAIL sat_restart actual=%0d required=1", hz2.stallcount);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_memstall();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
